// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: selects one read/write requester (round-robin or
// fixed priority) and runs it through a busy-handshake memory transaction.
module mem_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_read_req,
  input  logic [NUM_PORTS-1:0]             port_write_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data_write,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [DATA_WIDTH-1:0]            port_data_read,
  output logic                             memory_read_req,
  output logic                             memory_write_req,
  output logic [ADDR_WIDTH-1:0]            memory_addr,
  output logic [DATA_WIDTH-1:0]            memory_data_write,
  input  logic [DATA_WIDTH-1:0]            memory_data_read,
  input  logic                             memory_busy,
  output logic [2:0]                       grant_id,
  output logic                             active
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0] state;
  logic [2:0] rr_ptr;
  logic [2:0] next_ptr;
  logic       op_write;
  logic       issue_ok;
  logic       found;
  logic [2:0] sel;
  logic [3:0] cand;
  logic [7:0] req_pad;
  logic [7:0] wr_pad;
  logic [7:0] ack_pad;

  // Ports are zero-padded to 8 so a 3-bit index is always in range.
  assign req_pad  = 8'(port_read_req | port_write_req);
  assign wr_pad   = 8'(port_write_req);
  assign ack_pad  = 8'd1 << grant_id;
  assign next_ptr = (grant_id == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_id + 3'd1;

  // Pick the first requester scanning upward from rr_ptr (or from 0 in fixed mode).
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    cand  = 4'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (FIXED_PRIORITY != 0) begin
        cand = 4'(k);
      end else begin
        cand = {1'b0, rr_ptr} + 4'(k);
        if (cand >= 4'(NUM_PORTS)) begin
          cand = cand - 4'(NUM_PORTS);
        end else begin
          cand = cand;
        end
      end
      if (!found && req_pad[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end else begin
        found = found;
      end
    end
  end

  // Transaction sequencing, captured request and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= 3'd0;
      grant_id          <= 3'd0;
      op_write          <= 1'b0;
      memory_addr       <= '0;
      memory_data_write <= '0;
      port_data_read    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id          <= sel;
            op_write          <= wr_pad[sel];
            memory_addr       <= port_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            memory_data_write <= port_data_write[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (!memory_busy) state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (memory_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!memory_busy) begin
            state <= DONE;
            if (!op_write) port_data_read <= memory_data_read;
            if (FIXED_PRIORITY == 0) rr_ptr <= next_ptr;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The memory request is gated by busy so it pulses exactly once per transaction.
  assign issue_ok         = (state == ISSUE) && !memory_busy;
  assign memory_read_req  = issue_ok && !op_write;
  assign memory_write_req = issue_ok && op_write;
  assign active           = (state != IDLE);

  // One-hot completion pulse for the granted port during DONE.
  always_comb begin
    if (state == DONE) begin
      port_ack = ack_pad[NUM_PORTS-1:0];
    end else begin
      port_ack = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, busy/reset corner sequences,
// randomized round-robin traffic against a transaction-level model, fixed priority.
module tb_mem_arbiter;
  localparam int NP = 4;
  localparam int AW = 26;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [NP-1:0]     rd = '0, wr = '0;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP-1:0]     ack;
  logic [DW-1:0]     data_read;
  logic              mrd, mwr;
  logic [AW-1:0]     maddr;
  logic [DW-1:0]     mwdata;
  logic [DW-1:0]     mrdata = '0;
  logic              model_busy = 1'b0, extra_busy = 1'b0;
  wire               mbusy = model_busy | extra_busy;
  logic [2:0]        grant;
  logic              act;

  logic [NP-1:0]     f_rd = '0, f_wr = '0;
  logic [NP*AW-1:0]  f_addr = '0;
  logic [NP*DW-1:0]  f_wdata = '0;
  logic [NP-1:0]     f_ack;
  logic [DW-1:0]     f_dr;
  logic              f_mrd, f_mwr;
  logic [AW-1:0]     f_maddr;
  logic [DW-1:0]     f_mwdata;
  logic [DW-1:0]     f_mrdata = '0;
  logic              f_busy = 1'b0;
  logic [2:0]        f_grant;
  logic              f_act;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset), .port_read_req(rd), .port_write_req(wr), .port_addr(addr),
    .port_data_write(wdata), .port_ack(ack), .port_data_read(data_read),
    .memory_read_req(mrd), .memory_write_req(mwr), .memory_addr(maddr),
    .memory_data_write(mwdata), .memory_data_read(mrdata), .memory_busy(mbusy),
    .grant_id(grant), .active(act));

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset), .port_read_req(f_rd), .port_write_req(f_wr), .port_addr(f_addr),
    .port_data_write(f_wdata), .port_ack(f_ack), .port_data_read(f_dr),
    .memory_read_req(f_mrd), .memory_write_req(f_mwr), .memory_addr(f_maddr),
    .memory_data_write(f_mwdata), .memory_data_read(f_mrdata), .memory_busy(f_busy),
    .grant_id(f_grant), .active(f_act));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Memory responder: after each request pulse, busy rises for a chosen number of cycles.
  int          cfg_busy_len = 1;
  logic [DW-1:0] cfg_rdata = '0;
  bit          rand_mem = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mrd || mwr) begin
        int len;
        len = rand_mem ? int'($urandom_range(1, 4)) : cfg_busy_len;
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        mrdata = rand_mem ? $urandom : cfg_rdata;
        repeat (len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (f_mrd || f_mwr) begin
        @(posedge clk);
        #1 f_busy = 1'b1;
        @(posedge clk);
        #1 f_busy = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    rd[p] = r;
    wr[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Transaction-level reference state.
  bit            pend[NP];
  bit            pend_wr[NP];
  logic [AW-1:0] pend_a[NP];
  logic [DW-1:0] pend_d[NP];
  int            m_ptr, m_port, m_pulses, m_wait;
  bit            m_free;
  logic [DW-1:0] m_last_rd;
  int            ack_order[$];

  function automatic bit any_pending();
    for (int p = 0; p < NP; p++) if (pend[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_port = -1; m_free = 1'b1; m_last_rd = '0; m_pulses = 0; m_wait = 0;
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rd = '0; wr = '0; f_wr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_random(input int ncycles, input int pct, input bit wr_only);
    int just;
    bit drained;
    rand_mem = 1'b1;
    drained = 1'b0;
    for (int c = 0; c < ncycles + 400; c++) begin
      if (c >= ncycles && m_port < 0 && m_free && !any_pending()) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
      just = -1;
      if (mrd || mwr) begin
        m_pulses++;
        if (m_port < 0) begin
          check("rnd_unexpected_pulse", 64'({mrd, mwr}), 64'(0));
        end else begin
          check("rnd_op", 64'({mrd, mwr}), pend_wr[m_port] ? 64'(1) : 64'(2));
          check("rnd_addr", 64'(maddr), 64'(pend_a[m_port]));
          if (pend_wr[m_port]) check("rnd_wdata", 64'(mwdata), 64'(pend_d[m_port]));
        end
      end
      if (ack != '0) begin
        if (m_port < 0) begin
          check("rnd_unexpected_ack", 64'(ack), 64'(0));
        end else begin
          if (!pend_wr[m_port]) m_last_rd = mrdata;
          check("rnd_ack", 64'(ack), 64'(1) << m_port);
          check("rnd_grant", 64'(grant), 64'(m_port));
          check("rnd_pulses", 64'(m_pulses), 64'(1));
          check("rnd_data_read", 64'(data_read), 64'(m_last_rd));
          for (int p = 0; p < NP; p++) if (ack[p]) ack_order.push_back(p);
          m_ptr = (m_port + 1) % NP;
          pend[m_port] = 1'b0;
          set_port(m_port, 1'b0, 1'b0, '0, '0);
          just = m_port;
          m_port = -1;
        end
      end else if (m_port >= 0) begin
        m_wait++;
        if (m_wait > 40) begin
          check("rnd_ack_timeout", 64'(ack), 64'(1) << m_port);
          return;
        end
      end
      if (c < ncycles) begin
        for (int p = 0; p < NP; p++) begin
          if (!pend[p] && p != just && $urandom_range(0, 99) < pct) begin
            bit both;
            pend[p]    = 1'b1;
            pend_wr[p] = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
            pend_a[p]  = AW'($urandom);
            pend_d[p]  = $urandom;
            both       = !wr_only && pend_wr[p] && 1'($urandom_range(0, 1));
            set_port(p, !pend_wr[p] || both, pend_wr[p], pend_a[p], pend_d[p]);
          end
        end
      end
      // Grant rule: first pending port at or after the pointer, wrapping.
      if (m_free) begin
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_ptr + k) % NP;
          if (pend[p] && m_port < 0) m_port = p;
        end
        if (m_port >= 0) begin
          m_free = 1'b0; m_pulses = 0; m_wait = 0;
        end
      end
      if (just >= 0) m_free = 1'b1;
    end
    if (!drained) check("rnd_drain", 64'(any_pending()), 64'(0));
  endtask

  typedef struct {
    int            port;
    bit            r;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            busy;
    logic [DW-1:0] rdata;
    logic [NP-1:0] exp_ack;
    bit            exp_write;
    logic [DW-1:0] exp_dr;
    int            exp_cycles;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n, pulses;
    bit got;
    rand_mem = 1'b0; cfg_busy_len = v.busy; cfg_rdata = v.rdata;
    @(negedge clk);
    set_port(v.port, v.r, v.w, v.a, v.d);
    n = 0; pulses = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mrd || mwr) begin
        pulses++;
        check("vec_op", 64'({mrd, mwr}), v.exp_write ? 64'(1) : 64'(2));
        check("vec_addr", 64'(maddr), 64'(v.a));
        if (v.exp_write) check("vec_wdata", 64'(mwdata), 64'(v.d));
      end
      if (ack != '0) begin
        got = 1'b1;
        check("vec_ack", 64'(ack), 64'(v.exp_ack));
        check("vec_grant", 64'(grant), 64'(v.port));
        check("vec_data_read", 64'(data_read), 64'(v.exp_dr));
        check("vec_addr_at_done", 64'(maddr), 64'(v.a));
        set_port(v.port, 1'b0, 1'b0, '0, '0);
      end
    end
    check("vec_got_ack", 64'(got), 64'(1));
    check("vec_cycles", 64'(n + 1), 64'(v.exp_cycles));
    check("vec_pulses", 64'(pulses), 64'(1));
  endtask

  initial begin
    vec_t vt[5];
    int   pulses, n, acks;
    bit   got;

    vt[0] = '{2, 1'b1, 1'b0, 26'h0000123, 32'h0,        3, 32'hDEADBEEF, 4'b0100, 1'b0, 32'hDEADBEEF, 7};
    vt[1] = '{1, 1'b1, 1'b1, 26'h3FFFFFF, 32'hA5A5A5A5, 1, 32'h11111111, 4'b0010, 1'b1, 32'hDEADBEEF, 5};
    vt[2] = '{0, 1'b1, 1'b0, 26'h0000000, 32'h0,        1, 32'h12345678, 4'b0001, 1'b0, 32'h12345678, 5};
    vt[3] = '{3, 1'b0, 1'b1, 26'h1555555, 32'h00000000, 2, 32'h0BADF00D, 4'b1000, 1'b1, 32'h12345678, 6};
    vt[4] = '{3, 1'b1, 1'b0, 26'h2AAAAAA, 32'h0,        4, 32'hFFFFFFFF, 4'b1000, 1'b0, 32'hFFFFFFFF, 8};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_active", 64'(act), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_mem_req", 64'({mrd, mwr}), 64'(0));
    check("rst_maddr", 64'(maddr), 64'(0));
    check("rst_mwdata", 64'(mwdata), 64'(0));
    check("rst_data_read", 64'(data_read), 64'(0));
    check("rst_fp_active", 64'(f_act), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Memory busy already high when ISSUE is entered.
    rand_mem = 1'b0; cfg_busy_len = 1;
    @(negedge clk);
    extra_busy = 1'b1;
    set_port(0, 1'b1, 1'b0, 26'h0ABCDEF, 32'h0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (mrd || mwr) pulses++;
    end
    check("busy_hold_no_pulse", 64'(pulses), 64'(0));
    check("busy_hold_active", 64'(act), 64'(1));
    @(posedge clk);
    #1 extra_busy = 1'b0;
    pulses = 0; got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mrd || mwr) begin
        pulses++;
        check("busy_hold_addr", 64'(maddr), 64'(26'h0ABCDEF));
      end
      if (ack != '0) got = 1'b1;
    end
    check("busy_hold_ack", 64'(ack), 64'(4'b0001));
    check("busy_hold_pulses", 64'(pulses), 64'(1));
    set_port(0, 1'b0, 1'b0, '0, '0);

    // All ports writing continuously in round-robin mode.
    do_reset();
    ack_order.delete();
    run_random(40, 100, 1'b1);
    check("rr_order_len", 64'(ack_order.size() >= 5), 64'(1));
    for (int i = 0; i < ack_order.size(); i++) check("rr_order", 64'(ack_order[i]), 64'(i % 4));

    do_reset();
    run_random(600, 30, 1'b0);

    // Reset during WAIT_DONE abandons the transaction.
    rand_mem = 1'b0; cfg_busy_len = 4; cfg_rdata = 32'hCAFEF00D;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 26'h0123456, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mrd) got = 1'b1;
    end
    check("rst_mid_pulse_seen", 64'(got), 64'(1));
    repeat (2) @(negedge clk);
    check("rst_mid_active", 64'(act), 64'(1));
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_mid_ack", 64'(ack), 64'(0));
    check("rst_mid_active_clr", 64'(act), 64'(0));
    check("rst_mid_grant", 64'(grant), 64'(0));
    check("rst_mid_mem_req", 64'({mrd, mwr}), 64'(0));
    check("rst_mid_maddr", 64'(maddr), 64'(0));
    check("rst_mid_mwdata", 64'(mwdata), 64'(0));
    check("rst_mid_data_read", 64'(data_read), 64'(0));
    reset = 1'b0;
    model_reset();
    acks = 0; pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (mrd || mwr) pulses++;
    end
    check("rst_mid_no_ack", 64'(acks), 64'(0));
    check("rst_mid_no_pulse", 64'(pulses), 64'(0));
    cfg_busy_len = 1;
    set_port(3, 1'b0, 1'b1, 26'h3000001, 32'h77777777);
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mwr) check("rst_after_wdata", 64'(mwdata), 64'(32'h77777777));
      if (ack != '0) got = 1'b1;
    end
    check("rst_after_ack", 64'(ack), 64'(4'b1000));
    check("rst_after_grant", 64'(grant), 64'(3));
    set_port(3, 1'b0, 1'b0, '0, '0);

    // Fixed priority: port 0 keeps requesting and starves the others.
    do_reset();
    @(negedge clk);
    f_wr = 4'hF;
    for (int k = 0; k < 9; k++) begin
      int exp_idx;
      exp_idx = (k < 6) ? 0 : k - 5;
      got = 1'b0; n = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (f_ack != '0) got = 1'b1;
      end
      check("fp_ack", 64'(f_ack), 64'(1) << exp_idx);
      check("fp_grant", 64'(f_grant), 64'(exp_idx));
      if (k >= 5) f_wr[k-5] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
